// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared nop encoding and per-stage payload bundles for the MIPS pipeline
package mips_pipe_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

endpackage

// File: rtl/mips_pipe_elastic_reg_if.sv
// rtl/mips_pipe_elastic_reg_if.sv - valid/ready payload link between two pipeline stages
interface mips_pipe_elastic_reg_if #(
    parameter int WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mips_pipe_slot.sv
// rtl/mips_pipe_slot.sv - one valid+payload register; empty slots always hold the nop payload
module mips_pipe_slot
    import mips_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(MIPS_NOP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load in the same cycle as an unload replaces the departing payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mips_pipe_elastic_reg.sv
// rtl/mips_pipe_elastic_reg.sv - elastic multi-stage pipeline register with optional skid, flush and occupancy
module mips_pipe_elastic_reg
    import mips_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(MIPS_NOP)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_pipe_elastic_reg_if.slave        up_if,
    mips_pipe_elastic_reg_if.master       dn_if,
    input  logic                          flush,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 2);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] room;
    logic [DEPTH-1:0] move;
    logic [WIDTH-1:0] dat [DEPTH];
    logic             s0_space;
    logic             s0_load;
    logic [WIDTH-1:0] s0_data;
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_q, occ_d;

    // room[k]: whatever sits in stage k may move on this edge (next stage empty or itself moving).
    always_comb begin
        room          = '0;
        room[DEPTH-1] = dn_if.ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            room[k] = !vld[k+1] || room[k+1];
        end
    end

    assign move     = vld & room;
    assign s0_space = !vld[0] || room[0];
    assign in_fire  = up_if.valid && up_if.ready;
    assign out_fire = dn_if.valid && dn_if.ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_vld;
            logic [WIDTH-1:0] skid_dat;

            mips_pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush_i  (flush),
                .load_i   (in_fire && !s0_space),
                .unload_i (skid_vld && s0_space),
                .data_i   (up_if.data),
                .valid_o  (skid_vld),
                .data_o   (skid_dat)
            );

            // The parked payload always goes first, which keeps ordering FIFO.
            assign up_if.ready = !skid_vld;
            assign s0_load     = s0_space && (skid_vld || in_fire);
            assign s0_data     = skid_vld ? skid_dat : up_if.data;
        end else begin : g_noskid
            assign up_if.ready = s0_space;
            assign s0_load     = in_fire;
            assign s0_data     = up_if.data;
        end
    endgenerate

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             ld;
            logic [WIDTH-1:0] din;

            if (k == 0) begin : g_head
                assign ld  = s0_load;
                assign din = s0_data;
            end else begin : g_body
                assign ld  = move[k-1];
                assign din = dat[k-1];
            end

            mips_pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush_i  (flush),
                .load_i   (ld),
                .unload_i (move[k]),
                .data_i   (din),
                .valid_o  (vld[k]),
                .data_o   (dat[k])
            );
        end
    endgenerate

    assign dn_if.valid = vld[DEPTH-1];
    assign dn_if.data  = dat[DEPTH-1];

    always_comb begin
        occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
